// File: rtl/pc_unit.sv
// pc_unit: MIPS fetch-stage program counter with stall-deferred redirects and exception vectoring.
module pc_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned EXC_VECTOR   = 'h180,
  parameter int unsigned INC          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             in_kernel,
  output logic             redirect_pending
);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EV = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] IV = WIDTH'(INC);
  logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, pt_q, pt_d;
  logic             k_q, k_d, pv_q, pv_d;
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    k_d   = k_q;
    pv_d  = pv_q;
    pt_d  = pt_q;
    if (exc) begin
      epc_d = pc_q;
      pc_d  = EV;
      k_d   = 1'b1;
      pv_d  = 1'b0;
    end else if (eret) begin
      pc_d = epc_q;
      k_d  = 1'b0;
      pv_d = 1'b0;
    end else if (stall) begin
      if (jump || branch_taken) begin
        pt_d = jump ? jump_target : branch_target;
        pv_d = 1'b1;
      end
    end else begin
      pv_d = 1'b0;
      pc_d = jump ? jump_target : branch_taken ? branch_target : pv_q ? pt_q : pc_q + IV;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RV;
      epc_q <= '0;
      k_q   <= 1'b0;
      pv_q  <= 1'b0;
      pt_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      k_q   <= k_d;
      pv_q  <= pv_d;
      pt_q  <= pt_d;
    end
  end
  assign pc               = pc_q;
  assign pc_plus          = pc_q + IV;
  assign epc              = epc_q;
  assign in_kernel        = k_q;
  assign redirect_pending = pv_q;
endmodule
